// File: rtl/mmss_countdown.sv
// M:SS BCD countdown timer with start/stop/clear/load control and one-cycle done pulse.
// Optional internal 1 Hz prescaler compiled in with `define MMSS_PRESCALER_EN.
module mmss_countdown #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [3:0] load_dsec,
    input  logic [3:0] load_sec,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] min,
    output logic [3:0] dSec,
    output logic [3:0] sec,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] min_q, min_d;
    logic [3:0] dsec_q, dsec_d;
    logic [3:0] sec_q, sec_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       tick_int;
    logic       count_zero;

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("mmss_countdown: TICK_DIV must be at least 1");
    end

`ifdef MMSS_PRESCALER_EN
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             pre_clr;
    logic             unused_tick;

    assign unused_tick = tick;
    assign tick_int    = (state_q == S_RUN) && (pre_q == PRE_W'(TICK_DIV - 1));

    // Entering RUN can only come from an accepted start, so restart the second there.
    always_comb begin
        pre_clr = clear || (load && (state_q != S_RUN)) ||
                  ((state_q != S_RUN) && (state_d == S_RUN));
        pre_d   = pre_q;
        if (pre_clr) begin
            pre_d = '0;
        end else if (state_q == S_RUN) begin
            pre_d = tick_int ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick_int = tick;
`endif

    assign count_zero = (min_q == 4'd0) && (dsec_q == 4'd0) && (sec_q == 4'd0);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        dsec_d  = dsec_q;
        sec_d   = sec_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            min_d   = '0;
            dsec_d  = '0;
            sec_d   = '0;
        end else if (load && (state_q != S_RUN)) begin
            state_d = S_IDLE;
            min_d   = (load_min  > 4'd9) ? 4'd9 : load_min;
            dsec_d  = (load_dsec > 4'd5) ? 4'd5 : load_dsec;
            sec_d   = (load_sec  > 4'd9) ? 4'd9 : load_sec;
        end else if (stop) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSE;
            end
        end else if (start && ((state_q == S_IDLE) || (state_q == S_PAUSE))) begin
            if (!count_zero) begin
                state_d = S_RUN;
            end
        end else if (tick_int && (state_q == S_RUN)) begin
            if (sec_q != 4'd0) begin
                sec_d = sec_q - 4'd1;
            end else if (dsec_q != 4'd0) begin
                sec_d  = 4'd9;
                dsec_d = dsec_q - 4'd1;
            end else begin
                sec_d  = 4'd9;
                dsec_d = 4'd5;
                min_d  = min_q - 4'd1;
            end
            if ((min_d == 4'd0) && (dsec_d == 4'd0) && (sec_d == 4'd0)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            min_q     <= '0;
            dsec_q    <= '0;
            sec_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            dsec_q    <= dsec_d;
            sec_q     <= sec_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign min     = min_q;
    assign dSec    = dsec_q;
    assign sec     = sec_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mmss_countdown.sv
// Self-checking bench for mmss_countdown: directed vector table plus multi-cycle countdown,
// saturation, async-reset and (with MMSS_PRESCALER_EN) prescaler sequences.
module tb_mmss_countdown;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, load, start, stop, clear;
    logic [3:0] load_min, load_dsec, load_sec;
    logic [3:0] min, dSec, sec;
    logic       running, done;

    int errors = 0;
    int checks = 0;

    mmss_countdown #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .load      (load),
        .load_min  (load_min),
        .load_dsec (load_dsec),
        .load_sec  (load_sec),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .min       (min),
        .dSec      (dSec),
        .sec       (sec),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ctl = {clear, load, stop, start, tick}
    typedef struct {
        string      name;
        logic [4:0] ctl;
        logic [3:0] lm, ld, ls;
        logic [3:0] em, ed, es;
        logic       er, edn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n, input logic [4:0] c,
                       input logic [3:0] lm, input logic [3:0] ld, input logic [3:0] ls,
                       input logic [3:0] em, input logic [3:0] ed, input logic [3:0] es,
                       input logic er, input logic edn);
        vec_t v;
        v.name = n; v.ctl = c; v.lm = lm; v.ld = ld; v.ls = ls;
        v.em = em; v.ed = ed; v.es = es; v.er = er; v.edn = edn;
        tbl.push_back(v);
    endtask

    task automatic chk(input string n, input logic [14:0] exp);
        logic [14:0] act;
        act = {min, dSec, sec, running, done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got min/dsec/sec/run/done=%h/%h/%h/%b/%b expected %h/%h/%h/%b/%b",
                     n, act[14:11], act[10:7], act[6:3], act[2], act[1],
                     exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1]);
        end
    endtask

    function automatic logic [14:0] model(input int rem, input logic r, input logic d);
        return {4'(rem / 60), 4'((rem % 60) / 10), 4'(rem % 10), r, d};
    endfunction

    task automatic apply(input logic [4:0] c, input logic [3:0] lm,
                         input logic [3:0] ld, input logic [3:0] ls);
        {clear, load, stop, start, tick} = c;
        load_min = lm; load_dsec = ld; load_sec = ls;
        @(posedge clk);
        #1;
        {clear, load, stop, start, tick} = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        {clear, load, stop, start, tick} = '0;
        load_min = '0; load_dsec = '0; load_sec = '0;
        #2;
        chk("reset", 15'h0);
        #10 rst_n = 1'b1;

`ifndef MMSS_PRESCALER_EN
        add("load_3_20",     5'b01000, 4'd3, 4'd2, 4'd0, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0);
        add("start_3_20",    5'b00010, 4'd0, 4'd0, 4'd0, 4'd3, 4'd2, 4'd0, 1'b1, 1'b0);
        add("tick_3_19",     5'b00001, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd9, 1'b1, 1'b0);
        add("tick_3_18",     5'b00001, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd8, 1'b1, 1'b0);
        add("tick_3_17",     5'b00001, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd7, 1'b1, 1'b0);
        add("tick_3_16",     5'b00001, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd6, 1'b1, 1'b0);
        add("tick_3_15",     5'b00001, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd5, 1'b1, 1'b0);
        add("stop_tick",     5'b00101, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd5, 1'b0, 1'b0);
        add("tick_paused",   5'b00001, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd5, 1'b0, 1'b0);
        add("start_stop",    5'b00110, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd5, 1'b0, 1'b0);
        add("resume",        5'b00010, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd5, 1'b1, 1'b0);
        add("tick_3_14",     5'b00001, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd4, 1'b1, 1'b0);
        add("load_in_run",   5'b01000, 4'd4, 4'd0, 4'd0, 4'd3, 4'd1, 4'd4, 1'b1, 1'b0);
        add("clear_tick",    5'b10001, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        add("start_zero",    5'b00010, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        add("load_sat",      5'b01000, 4'd12, 4'd7, 4'd15, 4'd9, 4'd5, 4'd9, 1'b0, 1'b0);
        add("load_4_00",     5'b01000, 4'd4, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0);
        add("start_4_00",    5'b00010, 4'd0, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0);
        add("borrow_min",    5'b00001, 4'd0, 4'd0, 4'd0, 4'd3, 4'd5, 4'd9, 1'b1, 1'b0);
        add("stop_3_59",     5'b00100, 4'd0, 4'd0, 4'd0, 4'd3, 4'd5, 4'd9, 1'b0, 1'b0);
        add("load_paused",   5'b01000, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);
        add("start_0_10",    5'b00010, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0);
        add("borrow_dsec",   5'b00001, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
        add("stop_0_09",     5'b00100, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0);
        add("load_0_01",     5'b01000, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        add("start_0_01",    5'b00010, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        add("reach_zero",    5'b00001, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        add("done_drops",    5'b00000, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        add("start_in_done", 5'b00010, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        add("tick_in_done",  5'b00001, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        add("load_from_done",5'b01000, 4'd0, 4'd5, 4'd9, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0);
        add("start_0_59",    5'b00010, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
        add("clear_in_run",  5'b10000, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            apply(tbl[i].ctl, tbl[i].lm, tbl[i].ld, tbl[i].ls);
            chk(tbl[i].name, {tbl[i].em, tbl[i].ed, tbl[i].es, tbl[i].er, tbl[i].edn});
        end

        // 1:05 countdown, with one idle cycle mid-way that must hold the count
        apply(5'b01000, 4'd1, 4'd0, 4'd5);
        apply(5'b00010, 4'd0, 4'd0, 4'd0);
        chk("cd65_start", model(65, 1'b1, 1'b0));
        for (int i = 1; i <= 65; i++) begin
            apply(5'b00001, 4'd0, 4'd0, 4'd0);
            chk($sformatf("cd65_tick%0d", i), model(65 - i, (65 - i) != 0, (65 - i) == 0));
            if (i == 30) begin
                apply(5'b00000, 4'd0, 4'd0, 4'd0);
                chk("cd65_hold", model(35, 1'b1, 1'b0));
            end
        end
        apply(5'b00000, 4'd0, 4'd0, 4'd0);
        chk("cd65_after", model(0, 1'b0, 1'b0));

        // saturated load then full 599-tick run
        apply(5'b01000, 4'd12, 4'd7, 4'd15);
        chk("sat_9_59", model(599, 1'b0, 1'b0));
        apply(5'b00010, 4'd0, 4'd0, 4'd0);
        for (int i = 1; i <= 599; i++) begin
            apply(5'b00001, 4'd0, 4'd0, 4'd0);
            chk($sformatf("cd599_tick%0d", i), model(599 - i, (599 - i) != 0, (599 - i) == 0));
        end
        apply(5'b00000, 4'd0, 4'd0, 4'd0);
        chk("cd599_after", model(0, 1'b0, 1'b0));

        // asynchronous reset in the middle of a count
        apply(5'b01000, 4'd5, 4'd0, 4'd0);
        apply(5'b00010, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) apply(5'b00001, 4'd0, 4'd0, 4'd0);
        chk("pre_async", model(297, 1'b1, 1'b0));
`else
        // internal prescaler: tick port held high to show it is ignored
        apply(5'b01000, 4'd0, 4'd0, 4'd2);
        chk("pre_load", model(2, 1'b0, 1'b0));
        apply(5'b00010, 4'd0, 4'd0, 4'd0);
        chk("pre_start", model(2, 1'b1, 1'b0));
        tick = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pre_clk%0d", k), model(k < 4 ? 2 : (k < 8 ? 1 : 0), k < 8, k == 8));
        end
        tick = 1'b0;
        apply(5'b01000, 4'd0, 4'd3, 4'd0);
        apply(5'b00010, 4'd0, 4'd0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
        end
        #1;
        chk("pre_async", model(29, 1'b1, 1'b0));
`endif
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", 15'h0);
        #3 rst_n = 1'b1;
        apply(5'b00000, 4'd0, 4'd0, 4'd0);
        chk("after_reset", 15'h0);
        apply(5'b00010, 4'd0, 4'd0, 4'd0);
        chk("start_after_reset", 15'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
